// File: rtl/axi_lite2apb_bridge.sv
// AXI4-Lite slave to APB4 master bridge: one transaction at a time, round-robin
// between reads and writes, optional PREADY timeout that answers with SLVERR.
module axi_lite2apb_bridge #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 0
) (
    input  logic                PCLK_i,
    input  logic                PRESETn_i,
    input  logic                AWVALID_i,
    output logic                AWREADY_o,
    input  logic [ADDR_W-1:0]   AWADDR_i,
    input  logic [2:0]          AWPROT_i,
    input  logic                WVALID_i,
    output logic                WREADY_o,
    input  logic [DATA_W-1:0]   WDATA_i,
    input  logic [DATA_W/8-1:0] WSTRB_i,
    output logic                BVALID_o,
    input  logic                BREADY_i,
    output logic [1:0]          BRESP_o,
    input  logic                ARVALID_i,
    output logic                ARREADY_o,
    input  logic [ADDR_W-1:0]   ARADDR_i,
    input  logic [2:0]          ARPROT_i,
    output logic                RVALID_o,
    input  logic                RREADY_i,
    output logic [DATA_W-1:0]   RDATA_o,
    output logic [1:0]          RRESP_o,
    output logic                PSEL_o,
    output logic                PENABLE_o,
    output logic                PWRITE_o,
    output logic [ADDR_W-1:0]   PADDR_o,
    output logic [DATA_W-1:0]   PWDATA_o,
    output logic [DATA_W/8-1:0] PSTRB_o,
    output logic [2:0]          PPROT_o,
    input  logic [DATA_W-1:0]   PRDATA_i,
    input  logic                PREADY_i,
    input  logic                PSLVERR_i
);
    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

    state_e              state_q, state_d;
    logic                last_wr_q, is_wr_q, err_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q, rdata_q;
    logic [STRB_W-1:0]   strb_q;
    logic [2:0]          prot_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                wr_elig, rd_elig, acc_wr, acc_rd, timeout;

    // Write wins a tie unless it was the last one served.
    assign wr_elig = AWVALID_i & WVALID_i;
    assign rd_elig = ARVALID_i;
    assign acc_wr  = (state_q == IDLE) & wr_elig & (~rd_elig | ~last_wr_q);
    assign acc_rd  = (state_q == IDLE) & rd_elig & ~acc_wr;
    assign timeout = (TIMEOUT > 0) && !PREADY_i && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
        if (!PRESETn_i) state_q <= IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (acc_wr || acc_rd) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (PREADY_i || timeout) state_d = RESP;
            RESP:    if (is_wr_q ? BREADY_i : RREADY_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        AWREADY_o = acc_wr;
        WREADY_o  = acc_wr;
        ARREADY_o = acc_rd;
        PSEL_o    = (state_q == SETUP) || (state_q == ACCESS);
        PENABLE_o = (state_q == ACCESS);
        BVALID_o  = (state_q == RESP) && is_wr_q;
        RVALID_o  = (state_q == RESP) && !is_wr_q;
    end

    always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
        if (!PRESETn_i) begin
            last_wr_q <= 1'b0;
            is_wr_q   <= 1'b0;
            err_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            prot_q    <= '0;
            rdata_q   <= '0;
            cnt_q     <= '0;
        end else begin
            if (acc_wr) begin
                last_wr_q <= 1'b1;
                is_wr_q   <= 1'b1;
                addr_q    <= AWADDR_i;
                wdata_q   <= WDATA_i;
                strb_q    <= WSTRB_i;
                prot_q    <= AWPROT_i;
            end else if (acc_rd) begin
                last_wr_q <= 1'b0;
                is_wr_q   <= 1'b0;
                addr_q    <= ARADDR_i;
                prot_q    <= ARPROT_i;
            end
            if (state_q == SETUP) cnt_q <= '0;
            if (state_q == ACCESS) begin
                if (PREADY_i) begin
                    err_q <= PSLVERR_i;
                    if (!is_wr_q) rdata_q <= PRDATA_i;
                end else if (timeout) begin
                    err_q <= 1'b1;
                    if (!is_wr_q) rdata_q <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    // Write strobes are meaningless on reads, so they are forced low there.
    assign PWRITE_o = is_wr_q;
    assign PADDR_o  = addr_q;
    assign PWDATA_o = wdata_q;
    assign PSTRB_o  = is_wr_q ? strb_q : '0;
    assign PPROT_o  = prot_q;
    assign RDATA_o  = rdata_q;
    assign BRESP_o  = {err_q, 1'b0};
    assign RRESP_o  = {err_q, 1'b0};
endmodule
